fa_bist: RTL and testbench
==========================

FA_BIST -- requirements
Module: fa_bist

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning the number of cycles each vector is held on the DUT before sampling (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: synchronous and active-low.
REQ-004 SHALL have port start, input, 1, a run request, sampled each cycle.
REQ-005 SHALL have ports dut_a, dut_b and dut_cin, output, 1 each, stimulus driven to the full adder under test.
REQ-006 SHALL have ports dut_sum and dut_cout, input, 1 each, the response from the full adder under test.
REQ-007 SHALL have port busy, output, 1, high while a run is in progress.
REQ-008 SHALL have port done, output, 1, high once a run has completed, held until the next run starts or reset.
REQ-009 SHALL have port pass, output, 1, valid while done is high; 1 means zero mismatches.
REQ-010 SHALL have port err_count, output, 4, the number of mismatching vectors in the current or last run (0..8).
REQ-011 SHALL have port fail_valid, output, 1, high once at least one mismatch has been recorded.
REQ-012 SHALL have port first_fail, output, 3, the {a,b,cin} value of the first mismatching vector.

Function
REQ-013 SHALL implement the states IDLE, WAIT, CHECK and DONE.
REQ-014 SHALL accept start in IDLE or DONE; on acceptance the next state is WAIT, with idx=0, settle counter=SETTLE-1, err_count=0, fail_valid=0 and first_fail=0.
REQ-015 SHALL ignore start while in WAIT or CHECK; such a start has no effect on state or outputs.
REQ-016 SHALL drive {dut_a,dut_b,dut_cin}=idx (a is the MSB) combinationally from the idx register in WAIT and CHECK, and 3'b000 in IDLE and DONE.
REQ-017 SHALL decrement the settle counter each cycle in WAIT, and go to CHECK in the cycle after the counter reads 0, so that each vector spends exactly SETTLE cycles in WAIT.
REQ-018 SHALL in CHECK compare {dut_cout,dut_sum} against the 2-bit sum a+b+cin computed from idx.
REQ-019 SHALL on a CHECK mismatch increment err_count; if fail_valid is 0, it SHALL also set fail_valid=1 and first_fail=idx; later mismatches SHALL NOT change first_fail.
REQ-020 SHALL after CHECK with idx<7 increment idx, reload the settle counter with SETTLE-1 and return to WAIT.
REQ-021 SHALL after CHECK with idx=7 go to DONE; idx SHALL NOT wrap around.
REQ-022 SHALL take exactly 8*(SETTLE+1) cycles from the start-accept edge to the first cycle with done=1.
REQ-023 SHALL hold busy=1 in WAIT and CHECK, and 0 otherwise.
REQ-024 SHALL hold done=1 only in DONE.
REQ-025 SHALL drive pass=(err_count==0) in DONE, and 0 otherwise.
REQ-026 SHALL hold err_count, fail_valid and first_fail stable in DONE until a new start is accepted.
REQ-027 SHALL, when start is high in DONE, restart the run with the statistics cleared per REQ-014; done SHALL fall in the next cycle.
REQ-028 SHALL NOT saturate err_count; its maximum value is 8 and it cannot overflow 4 bits.

Reset
REQ-029 SHALL, while rst_n=0 at a rising clk edge, go to IDLE with idx=0, settle counter=0, err_count=0, fail_valid=0, first_fail=0, busy=0, done=0, pass=0 and dut_* all 0.
REQ-030 SHALL abort any run in progress on reset and discard partial results; reset takes priority over start in the same cycle.
REQ-031 SHALL, after reset is released, stay in IDLE until start=1.

Verification
REQ-032 SHALL verify a golden full adder with SETTLE=1 and a start pulse: done rises 16 cycles later, pass=1, err_count=0, fail_valid=0, and dut_* steps through 000..111.
REQ-033 SHALL verify a DUT with sum stuck at 0: err_count=4, fail_valid=1, first_fail=3'b001, pass=0.
REQ-034 SHALL verify a DUT with cout inverted: err_count=8, first_fail=3'b000, pass=0.
REQ-035 SHALL verify SETTLE=3 with a golden DUT: done after 32 cycles, and each idx value is held for 4 cycles.
REQ-036 SHALL verify that start pulsed while busy at idx=3 is ignored, and that rst_n=0 at idx=5 gives IDLE, all outputs 0 and dut_*=000 in the next cycle.
REQ-037 SHALL verify a restart from DONE after a failing run with a golden DUT: statistics are cleared at start, and the run ends with pass=1 and err_count=0.

Source files
------------

// File: rtl/fa_bist.sv
// fa_bist: built-in self test sequencer for a single-bit full adder.
// Walks all eight {a,b,cin} input combinations and holds each one for
// SETTLE cycles. It then compares the adder's {cout,sum} response with
// the arithmetic sum, counts mismatches and remembers the first failing
// vector.
`timescale 1ns/1ps

module fa_bist #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_cin,
  input  logic       dut_sum,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // The settle counter counts down from SETTLE-1 to 0, so WAIT lasts SETTLE cycles.
  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] settle_q, settle_d;
  logic [3:0] err_q, err_d;
  logic       fail_valid_q, fail_valid_d;
  logic [2:0] first_fail_q, first_fail_d;

  logic [1:0] expected_sum;
  logic       mismatch;
  logic       run_active;

  // Reference sum of the three stimulus bits and the per-vector compare result.
  always_comb begin
    expected_sum = {1'b0, idx_q[2]} + {1'b0, idx_q[1]} + {1'b0, idx_q[0]};
    mismatch     = ({dut_cout, dut_sum} != expected_sum);
  end

  // Next-state and datapath update. Every register holds its value by default.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = WAIT;
          idx_d        = 3'd0;
          settle_d     = SETTLE_RELOAD;
          err_d        = 4'd0;
          fail_valid_d = 1'b0;
          first_fail_d = 3'd0;
        end
      end

      WAIT: begin
        if (settle_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_fail_d = idx_q;
          end
        end
        if (idx_q == 3'd7) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + 3'd1;
          settle_d = SETTLE_RELOAD;
          state_d  = WAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and statistics registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      settle_q     <= 4'd0;
      err_q        <= 4'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  // Status flags and stimulus decoded from the current state and index.
  always_comb begin
    run_active = (state_q == WAIT) || (state_q == CHECK);
    busy       = run_active;
    done       = (state_q == DONE);
    pass       = (state_q == DONE) && (err_q == 4'd0);
    dut_a      = 1'b0;
    dut_b      = 1'b0;
    dut_cin    = 1'b0;
    if (run_active) begin
      dut_a   = idx_q[2];
      dut_b   = idx_q[1];
      dut_cin = idx_q[0];
    end
  end

  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_fa_bist.sv
// Testbench for fa_bist. Two instances are used, with SETTLE=1 and SETTLE=3.
// Each one drives a table-driven full adder model whose truth table
// is either golden, a known fault, or randomly corrupted. Expected
// statistics are derived directly from that truth table.
`timescale 1ns/1ps

module tb_fa_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_v  [2];
  logic       start_v  [2];
  logic       a_w      [2];
  logic       b_w      [2];
  logic       c_w      [2];
  logic       sum_w    [2];
  logic       cout_w   [2];
  logic       busy_w   [2];
  logic       done_w   [2];
  logic       pass_w   [2];
  logic       fv_w     [2];
  logic [3:0] err_w    [2];
  logic [2:0] ff_w     [2];

  // Response table of the adder under test, indexed by {a,b,cin}, value {cout,sum}
  logic [1:0] resp_tbl [2][8];

  int checks = 0;
  int errors = 0;
  bit aborted;

  assign sum_w[0]  = resp_tbl[0][{a_w[0], b_w[0], c_w[0]}][0];
  assign cout_w[0] = resp_tbl[0][{a_w[0], b_w[0], c_w[0]}][1];
  assign sum_w[1]  = resp_tbl[1][{a_w[1], b_w[1], c_w[1]}][0];
  assign cout_w[1] = resp_tbl[1][{a_w[1], b_w[1], c_w[1]}][1];

  fa_bist #(.SETTLE(1)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n_v[0]),
    .start     (start_v[0]),
    .dut_a     (a_w[0]),
    .dut_b     (b_w[0]),
    .dut_cin   (c_w[0]),
    .dut_sum   (sum_w[0]),
    .dut_cout  (cout_w[0]),
    .busy      (busy_w[0]),
    .done      (done_w[0]),
    .pass      (pass_w[0]),
    .err_count (err_w[0]),
    .fail_valid(fv_w[0]),
    .first_fail(ff_w[0])
  );

  fa_bist #(.SETTLE(3)) u_s3 (
    .clk       (clk),
    .rst_n     (rst_n_v[1]),
    .start     (start_v[1]),
    .dut_a     (a_w[1]),
    .dut_b     (b_w[1]),
    .dut_cin   (c_w[1]),
    .dut_sum   (sum_w[1]),
    .dut_cout  (cout_w[1]),
    .busy      (busy_w[1]),
    .done      (done_w[1]),
    .pass      (pass_w[1]),
    .err_count (err_w[1]),
    .fail_valid(fv_w[1]),
    .first_fail(ff_w[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0 golden, 1 sum stuck at 0, 2 cout inverted, 3 random corruption
  task automatic setTable(input int inst, input int mode);
    for (int i = 0; i < 8; i++) begin
      int s;
      logic [1:0] g;
      s = i[2] + i[1] + i[0];
      g = 2'(s);
      case (mode)
        1:       resp_tbl[inst][i] = {g[1], 1'b0};
        2:       resp_tbl[inst][i] = {~g[1], g[0]};
        3:       resp_tbl[inst][i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : g;
        default: resp_tbl[inst][i] = g;
      endcase
    end
  endtask

  // Expected statistics: count the table entries that are not a true sum
  task automatic modelExpect(input int inst, output int e_err, output logic e_fv,
                             output logic [2:0] e_ff);
    e_err = 0;
    e_fv  = 1'b0;
    e_ff  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (int'(resp_tbl[inst][i]) != (i[2] + i[1] + i[0])) begin
        if (e_err == 0) begin
          e_fv = 1'b1;
          e_ff = 3'(i);
        end
        e_err++;
      end
    end
  endtask

  task automatic checkIdle(input int inst, input string tag);
    checkOutput({tag, "_flags"}, {busy_w[inst], done_w[inst], pass_w[inst], fv_w[inst]}, 8'h0);
    checkOutput({tag, "_vec"}, {a_w[inst], b_w[inst], c_w[inst]}, 8'h0);
    checkOutput({tag, "_err"}, err_w[inst], 8'h0);
    checkOutput({tag, "_ff"}, ff_w[inst], 8'h0);
  endtask

  task automatic checkStats(input int inst, input string tag);
    int e_err;
    logic e_fv;
    logic [2:0] e_ff;
    modelExpect(inst, e_err, e_fv, e_ff);
    checkOutput({tag, "_err"}, err_w[inst], 8'(e_err));
    checkOutput({tag, "_fv"}, fv_w[inst], e_fv);
    checkOutput({tag, "_ff"}, ff_w[inst], e_ff);
    checkOutput({tag, "_pass"}, pass_w[inst], (e_err == 0));
    checkOutput({tag, "_done"}, done_w[inst], 1'b1);
  endtask

  // Pulse start for one cycle; returns at the sample right after the accept edge
  task automatic applyStimulus(input int inst);
    start_v[inst] = 1'b1;
    step();
    start_v[inst] = 1'b0;
  endtask

  // Follow a run cycle by cycle. glitch_n pulses start at that sample, reset_n
  // asserts reset at that sample (-1 disables either).
  task automatic runVectors(input int inst, input int settle, input int glitch_n,
                            input int reset_n, output bit was_aborted);
    int t;
    t = 8 * (settle + 1);
    was_aborted = 1'b0;
    applyStimulus(inst);
    for (int n = 0; n <= t; n++) begin
      logic [2:0] exp_vec;
      exp_vec = (n < t) ? 3'(n / (settle + 1)) : 3'd0;
      checkOutput("vector", {a_w[inst], b_w[inst], c_w[inst]}, exp_vec);
      checkOutput("busy", busy_w[inst], (n < t));
      checkOutput("done_timing", done_w[inst], (n == t));
      if (n == 0) begin
        checkOutput("cleared_err", err_w[inst], 8'h0);
        checkOutput("cleared_fv", fv_w[inst], 8'h0);
        checkOutput("cleared_ff", ff_w[inst], 8'h0);
      end
      if (n == reset_n) begin
        rst_n_v[inst] = 1'b0;
        step();
        rst_n_v[inst] = 1'b1;
        checkIdle(inst, "abort");
        for (int k = 0; k < 3; k++) begin
          step();
          checkIdle(inst, "idle_after_abort");
        end
        was_aborted = 1'b1;
        return;
      end
      start_v[inst] = (n == glitch_n);
      if (n < t) step();
    end
    start_v[inst] = 1'b0;
    checkStats(inst, "final");
  endtask

  // Statistics must stay put while sitting in DONE
  task automatic holdCheck(input int inst);
    for (int k = 0; k < 3; k++) step();
    checkStats(inst, "hold");
  endtask

  initial begin
    rst_n_v[0] = 1'b0;
    rst_n_v[1] = 1'b0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    setTable(0, 0);
    setTable(1, 0);

    $display("[TB] reset");
    step();
    step();
    checkIdle(0, "reset_s1");
    checkIdle(1, "reset_s3");
    rst_n_v[0] = 1'b1;
    rst_n_v[1] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checkIdle(0, "idle_s1");
    checkIdle(1, "idle_s3");

    $display("[TB] golden SETTLE=1");
    runVectors(0, 1, -1, -1, aborted);
    holdCheck(0);

    $display("[TB] sum stuck at 0");
    setTable(0, 1);
    runVectors(0, 1, -1, -1, aborted);
    checkOutput("stuck_err_const", err_w[0], 8'd4);
    checkOutput("stuck_ff_const", ff_w[0], 8'd1);
    holdCheck(0);

    $display("[TB] cout inverted");
    setTable(0, 2);
    runVectors(0, 1, -1, -1, aborted);
    checkOutput("inv_err_const", err_w[0], 8'd8);
    checkOutput("inv_ff_const", ff_w[0], 8'd0);

    $display("[TB] restart from DONE with golden adder");
    setTable(0, 0);
    runVectors(0, 1, -1, -1, aborted);
    checkOutput("restart_pass", pass_w[0], 8'd1);

    $display("[TB] start pulsed at idx 3 is ignored");
    setTable(0, 1);
    runVectors(0, 1, 6, -1, aborted);

    $display("[TB] random fault tables SETTLE=1");
    for (int r = 0; r < 8; r++) begin
      setTable(0, 3);
      runVectors(0, 1, -1, -1, aborted);
    end

    $display("[TB] reset at idx 5");
    setTable(0, 2);
    runVectors(0, 1, -1, 10, aborted);
    checkOutput("aborted_flag", aborted, 8'd1);
    setTable(0, 0);
    runVectors(0, 1, -1, -1, aborted);

    $display("[TB] golden SETTLE=3");
    runVectors(1, 3, -1, -1, aborted);
    holdCheck(1);

    $display("[TB] random fault tables SETTLE=3");
    for (int r = 0; r < 4; r++) begin
      setTable(1, 3);
      runVectors(1, 3, -1, -1, aborted);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
